iic_master: RTL and testbench

IIC_MASTER -- requirements
Module: iic_master

---
 rtl/iic_master.sv | 209 ++++++++++++++++++++
 tb/tb_iic_master.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_master.sv
// ---------------------------------------------------------------------------
// iic_master -- single-byte I2C bus master (write or read one byte).
//
// One SCL bit is four quarters of DIV GCLK cycles each. A transaction is
// START, address byte {dev_addr, rw}, address ACK, one data byte, data ACK,
// STOP, then a one-cycle DONE. A NACKed address skips the data byte.
//
// Ports
//   GCLK      system clock, rising edge
//   RESET     asynchronous active-low reset
//   start     one-cycle request, accepted only when idle
//   rw        0 = write wdata, 1 = read into rdata (latched on accept)
//   dev_addr  7-bit target address (latched on accept)
//   wdata     byte to write (latched on accept)
//   rdata     byte read, valid with done after a read
//   busy      transaction in progress
//   done      one-cycle completion pulse
//   ack_err   a slave NACK was seen in the last transaction
//   IICING    copy of busy for the far-end coordinator
//   SCL       bus clock, driven at both levels
//   SDA       open-drain data, driven low or left high-Z
// ---------------------------------------------------------------------------
module iic_master #(
    parameter int DIV = 25
) (
    input  logic       GCLK,
    input  logic       RESET,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       IICING,
    output logic       SCL,
    inout  wire        SDA
);

    localparam int QW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_AACK, S_DATA, S_DACK, S_STOP, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;      // GCLK cycles within a quarter
    logic [1:0]      q_q, q_d;            // quarter within the bit
    logic [2:0]      bit_q, bit_d;        // bit of the current byte, 7..0
    logic            rw_q, rw_d;
    logic [6:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            ack_err_q, ack_err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            scl_q, scl_d;
    logic            sda_low_q, sda_low_d;

    logic            quarter_end, bit_end, sample;
    logic            sda_in;
    logic [7:0]      addr_byte;

    assign sda_in = SDA;

    // NOTE: every signal assigned in this always_comb gets a default first,
    // so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        q_d       = q_q;
        bit_d     = bit_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ack_err_d = ack_err_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        quarter_end = (qcnt_q == QW'(DIV - 1));
        bit_end     = quarter_end && (q_q == 2'd3);
        // Bus is sampled on the last GCLK cycle of q2, mid-way through SCL high.
        sample      = quarter_end && (q_q == 2'd2);

        if (state_q != S_IDLE && state_q != S_DONE) begin
            qcnt_d = quarter_end ? '0 : qcnt_q + QW'(1);
            if (quarter_end) q_d = q_q + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_START;
                    rw_d      = rw;
                    addr_d    = dev_addr;
                    wdata_d   = wdata;
                    ack_err_d = 1'b0;
                    busy_d    = 1'b1;
                    qcnt_d    = '0;
                    q_d       = 2'd0;
                    bit_d     = 3'd0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_ADDR;
                    bit_d   = 3'd7;
                end
            end
            S_ADDR: begin
                // Decrementing past 0 wraps to 7, ready for the next byte.
                if (bit_end) begin
                    bit_d = bit_q - 3'd1;
                    if (bit_q == 3'd0) state_d = S_AACK;
                end
            end
            S_AACK: begin
                if (sample && sda_in) ack_err_d = 1'b1;
                // ack_err was cleared on accept, so it holds this bit's sample.
                if (bit_end) state_d = ack_err_q ? S_STOP : S_DATA;
            end
            S_DATA: begin
                if (sample && rw_q) rdata_d = {rdata_q[6:0], sda_in};
                if (bit_end) begin
                    bit_d = bit_q - 3'd1;
                    if (bit_q == 3'd0) state_d = S_DACK;
                end
            end
            S_DACK: begin
                // A read ends with the master's own NACK, so only writes check.
                if (sample && !rw_q && sda_in) ack_err_d = 1'b1;
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // Bus pins are registered from the next-state view so they line up
        // with the state/quarter registers they belong to.
        addr_byte = {addr_d, rw_d};
        scl_d     = q_d[1];
        sda_low_d = 1'b0;
        case (state_d)
            S_IDLE, S_DONE: scl_d = 1'b1;
            S_START: begin
                scl_d     = 1'b1;
                sda_low_d = q_d[1];
            end
            S_ADDR:  sda_low_d = ~addr_byte[bit_d];
            S_DATA:  sda_low_d = ~rw_d & ~wdata_d[bit_d];
            S_STOP:  sda_low_d = (q_d != 2'd3);
            default: sda_low_d = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge GCLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            qcnt_q    <= '0;
            q_q       <= 2'd0;
            bit_q     <= 3'd0;
            rw_q      <= 1'b0;
            addr_q    <= 7'd0;
            wdata_q   <= 8'd0;
            rdata_q   <= 8'd0;
            ack_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_low_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            q_q       <= q_d;
            bit_q     <= bit_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ack_err_q <= ack_err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            scl_q     <= scl_d;
            sda_low_q <= sda_low_d;
        end
    end

    assign rdata   = rdata_q;
    assign busy    = busy_q;
    assign IICING  = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign SCL     = scl_q;
    assign SDA     = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_iic_master.sv
// ---------------------------------------------------------------------------
// tb_iic_master -- self-checking bench for iic_master (DIV = 4).
//
// SDA has a pull-up. A bus monitor records START/STOP events and the SDA
// level at every SCL rise; a responder drives ACKs and read data on SCL
// falls. Each transaction's expected bus bits, ack_err, rdata and latency
// come from a byte-level model of the protocol.
// ---------------------------------------------------------------------------
module tb_iic_master;

    localparam int DIV = 4;

    logic       gclk = 1'b0;
    logic       reset_n = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] dev_addr = 7'd0;
    logic [7:0] wdata = 8'd0;
    wire  [7:0] rdata;
    wire        busy, done, ack_err, iicing, scl;
    wire        sda;

    int total = 0;
    int bad = 0;

    // Responder configuration, set by the test tasks.
    logic       resp_en = 1'b1;
    logic       resp_data_ack = 1'b1;
    logic [7:0] resp_byte = 8'h00;

    // Monitor / responder state, owned by the monitor process.
    logic       resp_drive = 1'b0;
    logic       scl_prev = 1'b1;
    logic       sda_prev = 1'b1;
    logic       in_txn = 1'b0;
    logic       resp_rw = 1'b0;
    int         bitpos = -1;
    int         bit_n = 0;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    logic       bits_arr [0:31];

    pullup (sda);
    assign sda = resp_drive ? 1'b0 : 1'bz;
    wire sda_bit = (sda === 1'b0) ? 1'b0 : 1'b1;

    iic_master #(.DIV(DIV)) dut (
        .GCLK     (gclk),
        .RESET    (reset_n),
        .start    (start),
        .rw       (rw),
        .dev_addr (dev_addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .IICING   (iicing),
        .SCL      (scl),
        .SDA      (sda)
    );

    always #5 gclk = ~gclk;

    // Does the responder pull SDA low during bit position pos?
    // Positions 0-7 address, 8 address ACK, 9-16 data, 17 data ACK.
    function automatic logic resp_wants_low(input int pos);
        if (!resp_en) return 1'b0;
        if (pos == 8) return 1'b1;
        if (resp_rw && pos >= 9 && pos <= 16) return ~resp_byte[16 - pos];
        if (!resp_rw && pos == 17) return resp_data_ack;
        return 1'b0;
    endfunction

    // Any SDA change with SCL held high is a START (fall) or STOP (rise); a
    // stray change therefore shows up as an extra event or a broken bit count.
    always @(negedge gclk) begin
        scl_prev <= scl;
        sda_prev <= sda_bit;
        if (!reset_n) begin
            resp_drive <= 1'b0;
            in_txn     <= 1'b0;
        end else if (scl_prev && scl && (sda_bit != sda_prev)) begin
            resp_drive <= 1'b0;
            if (!sda_bit) begin
                start_cnt <= start_cnt + 1;
                in_txn    <= 1'b1;
                bitpos    <= -1;
                bit_n     <= 0;
            end else begin
                stop_cnt <= stop_cnt + 1;
                in_txn   <= 1'b0;
            end
        end else if (in_txn && !scl_prev && scl) begin
            if (bit_n < 32) bits_arr[bit_n] <= sda_bit;
            bit_n <= bit_n + 1;
            if (bitpos == 7) resp_rw <= sda_bit;
        end else if (in_txn && scl_prev && !scl) begin
            bitpos     <= bitpos + 1;
            resp_drive <= resp_wants_low(bitpos + 1);
        end
    end

    task automatic accept(input logic [6:0] a, input logic r, input logic [7:0] w);
        @(posedge gclk); #1;
        start = 1'b1; rw = r; dev_addr = a; wdata = w;
        @(posedge gclk); #1;
        start = 1'b0;
    endtask

    // One full transaction, checked against the byte-level model.
    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] w,
                           input logic en, input logic dack, input logic [7:0] rb,
                           input logic mid_start, input string name);
        logic       exp_bits [0:19];
        logic [7:0] abyte, dbyte;
        int         exp_n, quarters, cycles, s0, p0, bit_bad, iic_bad;
        logic       exp_err;

        resp_en = en; resp_data_ack = dack; resp_byte = rb;
        abyte = {a, r};
        dbyte = r ? rb : w;
        for (int i = 0; i < 8; i++) exp_bits[i] = abyte[7 - i];
        exp_bits[8] = ~en;
        if (en) begin
            for (int i = 0; i < 8; i++) exp_bits[9 + i] = dbyte[7 - i];
            exp_bits[17] = r ? 1'b1 : ~dack;
            exp_bits[18] = 1'b0;        // SCL rise inside STOP, SDA still low
            exp_n = 19;
            quarters = 4 + 4 * 18 + 4;
        end else begin
            exp_bits[9] = 1'b0;
            exp_n = 10;
            quarters = 4 + 4 * 9 + 4;
        end
        exp_err = ~en | (~r & ~dack);

        s0 = start_cnt; p0 = stop_cnt;
        accept(a, r, w);
        total++;
        if (busy !== 1'b1 || iicing !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_after_accept: busy=%b IICING=%b want 1/1", name, busy, iicing);
        end

        cycles = 0; iic_bad = 0;
        while (cycles < 1000) begin
            @(posedge gclk); #1;
            cycles++;
            if (mid_start && cycles == 30) begin
                start = 1'b1; wdata = ~w; dev_addr = ~a; rw = ~r;
            end else begin
                start = 1'b0;
            end
            if (iicing !== busy) iic_bad++;
            if (done === 1'b1) break;
        end
        start = 1'b0;

        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s done_timeout: no done within %0d cycles", name, cycles);
        end
        total++;
        if (cycles < quarters * DIV || cycles > quarters * DIV + 2) begin
            bad++;
            $display("FAIL %s latency: got %0d cycles want %0d..%0d", name, cycles,
                     quarters * DIV, quarters * DIV + 2);
        end
        total++;
        if (ack_err !== exp_err) begin
            bad++;
            $display("FAIL %s ack_err: got %b want %b", name, ack_err, exp_err);
        end
        if (r && en) begin
            total++;
            if (rdata !== rb) begin
                bad++;
                $display("FAIL %s rdata: got %h want %h", name, rdata, rb);
            end
        end
        total++;
        if (iic_bad != 0) begin
            bad++;
            $display("FAIL %s iicing_eq_busy: %0d cycles differ, want 0", name, iic_bad);
        end

        @(posedge gclk); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s done_one_cycle: done=%b busy=%b want 0/0", name, done, busy);
        end

        total++;
        if (start_cnt - s0 != 1 || stop_cnt - p0 != 1) begin
            bad++;
            $display("FAIL %s start_stop: starts=%0d stops=%0d want 1/1", name,
                     start_cnt - s0, stop_cnt - p0);
        end
        bit_bad = 0;
        for (int i = 0; i < exp_n && i < bit_n; i++)
            if (bits_arr[i] !== exp_bits[i]) bit_bad++;
        total++;
        if (bit_n != exp_n || bit_bad != 0) begin
            bad++;
            $display("FAIL %s bus_bits: count=%0d wrong=%0d want count=%0d wrong=0", name,
                     bit_n, bit_bad, exp_n);
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (scl !== 1'b1 || sda !== 1'b1 || busy !== 1'b0 || iicing !== 1'b0 ||
            done !== 1'b0 || ack_err !== 1'b0 || rdata !== 8'h00) begin
            bad++;
            $display("FAIL reset_state: scl=%b sda=%b busy=%b iic=%b done=%b err=%b rdata=%h want 1 1 0 0 0 0 00",
                     scl, sda, busy, iicing, done, ack_err, rdata);
        end
        repeat (3) @(posedge gclk);
        #2 reset_n = 1'b1;
        repeat (20) @(posedge gclk);
        #1;
        total++;
        if (busy !== 1'b0 || scl !== 1'b1 || sda !== 1'b1) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b scl=%b sda=%b want 0 1 1", busy, scl, sda);
        end
    endtask

    task automatic test_write();
        run_txn(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, "write_50_A5");
    endtask

    task automatic test_read();
        run_txn(7'h50, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, "read_50_3C");
    endtask

    task automatic test_addr_nack();
        run_txn(7'h50, 1'b0, 8'h5A, 1'b0, 1'b1, 8'h00, 1'b0, "addr_nack");
    endtask

    task automatic test_data_nack();
        run_txn(7'h22, 1'b0, 8'h81, 1'b1, 1'b0, 8'h00, 1'b0, "data_nack");
    endtask

    task automatic test_ignore_start();
        run_txn(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b1, "start_while_busy");
    endtask

    task automatic test_reset_mid();
        int cycles;
        resp_en = 1'b1; resp_data_ack = 1'b1;
        accept(7'h50, 1'b0, 8'hFF);
        // Data byte begins 40 quarters after accept; bit 3 is its fifth bit.
        cycles = 0;
        while (cycles < 40 * DIV + 4 * 4 * DIV + 6) begin
            @(posedge gclk);
            cycles++;
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (scl !== 1'b1 || sda !== 1'b1 || busy !== 1'b0 || iicing !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_data: scl=%b sda=%b busy=%b iic=%b done=%b want 1 1 0 0 0",
                     scl, sda, busy, iicing, done);
        end
        repeat (3) @(posedge gclk);
        #2 reset_n = 1'b1;
        repeat (10) @(posedge gclk);
        #1;
        total++;
        if (busy !== 1'b0 || scl !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_idle: busy=%b scl=%b want 0 1", busy, scl);
        end
        run_txn(7'h50, 1'b0, 8'h96, 1'b1, 1'b1, 8'h00, 1'b0, "write_after_reset");
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            logic [6:0] a;
            logic [7:0] w, rb;
            logic r, en, dack;
            a    = 7'($urandom);
            w    = 8'($urandom);
            rb   = 8'($urandom);
            r    = 1'($urandom);
            en   = ($urandom_range(0, 4) != 0);
            dack = ($urandom_range(0, 3) != 0);
            run_txn(a, r, w, en, dack, rb, 1'b0, $sformatf("random_%0d", k));
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_data_nack();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
